// File: rtl/ef_pkg.sv
// Shared constants and types for the E/F step counter and its sequencer.
package ef_pkg;

  // Counter states
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  // F encoding
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } ef_state_e;

  // Upward distance from cur to tgt; 2-bit subtraction wraps modulo 4.
  function automatic logic [1:0] ef_dist_up(input logic [1:0] tgt, input logic [1:0] cur);
    return tgt - cur;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Pointer names the preferred requester on contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_ptr;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves to the requester that did not just win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/ef_step_sequencer.sv
// Arbitrates two requesters for the shared E/F step counter and steps it along the shortest
// path to the granted target, finishing with a per-requester done pulse.
module ef_step_sequencer
  import ef_pkg::*;
#(
  parameter int unsigned STEP_LIMIT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] tgt0,
  input  logic [1:0] tgt1,
  output logic [1:0] req_ready,
  input  logic [1:0] present,
  output logic       E,
  output logic       F,
  output logic [1:0] done,
  output logic       err,
  output logic       busy
);

  localparam logic [2:0] StepLimit = 3'(STEP_LIMIT);

  ef_state_e  r_state;
  logic [1:0] r_tgt;
  logic       r_id;
  logic [2:0] r_steps;
  logic [1:0] r_done;
  logic       r_err;

  logic [1:0] w_arb_req;
  logic [1:0] w_gnt;
  logic       w_accept;
  logic [1:0] w_dup;
  logic       w_at_tgt;
  logic       w_limit;
  logic       w_step;

  // Requests are only visible to the arbiter while idle, which also forces ready low otherwise.
  assign w_arb_req = (r_state == IDLE) ? req_valid : 2'b00;
  assign w_accept  = (w_gnt != 2'b00);
  assign req_ready = w_gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (w_arb_req),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // Path is recomputed from live present every cycle so external counter moves are tracked.
  always_comb begin
    w_dup    = ef_dist_up(r_tgt, present);
    w_at_tgt = (present == r_tgt);
    w_limit  = (r_steps == StepLimit);
    w_step   = (r_state == MOVE) && !w_at_tgt && !w_limit;
    E        = w_step;
    F        = w_step ? ((w_dup <= 2'd2) ? DIR_UP : DIR_DN) : DIR_DN;
  end

  assign done = r_done;
  assign err  = r_err;
  assign busy = (r_state != IDLE);

  // Main FSM with registered done/err, which are set on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tgt   <= S0;
      r_id    <= 1'b0;
      r_steps <= 3'd0;
      r_done  <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tgt   <= w_gnt[1] ? tgt1 : tgt0;
            r_id    <= w_gnt[1];
            r_steps <= 3'd0;
            r_state <= MOVE;
          end
        end
        MOVE: begin
          if (w_at_tgt) begin
            r_state      <= DONE;
            r_done[r_id] <= 1'b1;
          end else if (w_limit) begin
            r_state      <= DONE;
            r_done[r_id] <= 1'b1;
            r_err        <= 1'b1;
          end else begin
            r_steps <= r_steps + 3'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ef_step_sequencer.sv
// Closed-loop bench: sequencer driving a behavioural E/F counter.
module tb_ef_step_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] tgt0;
  logic [1:0] tgt1;
  logic [1:0] req_ready;
  logic [1:0] present;
  logic       E;
  logic       F;
  logic [1:0] done;
  logic       err;
  logic       busy;

  // Counter model controls
  logic       load;
  logic [1:0] load_val;
  logic       hold;

  int tests = 0;
  int fails = 0;

  ef_step_sequencer #(.STEP_LIMIT(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .tgt0      (tgt0),
    .tgt1      (tgt1),
    .req_ready (req_ready),
    .present   (present),
    .E         (E),
    .F         (F),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural E/F counter; hold freezes it to emulate an external stall.
  always @(posedge clk) begin
    if (load) present <= load_val;
    else if (!hold && E) present <= F ? present + 2'd1 : present - 2'd1;
  end

  typedef struct {
    logic [1:0] p;
    logic [1:0] valid;
    logic [1:0] t0;
    logic [1:0] t1;
    logic       hold;
    logic [1:0] gnt;
    int         lat;
    int         steps;
    logic       dir;
    logic       err;
    logic [1:0] fin;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Load the counter; starts and ends at a negedge.
  task automatic set_present(input logic [1:0] p);
    load     = 1'b1;
    load_val = p;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   lat;
    int   ecnt;
    logic dirok;
    logic got;
    hold = v.hold;
    set_present(v.p);
    tgt0      = v.t0;
    tgt1      = v.t1;
    req_valid = v.valid;
    #1 chk($sformatf("v%0d ready", idx), req_ready, v.gnt);
    @(negedge clk);
    req_valid = 2'b00;
    lat   = 1;
    ecnt  = 0;
    dirok = 1'b1;
    got   = 1'b0;
    while (lat < 30) begin
      #1;
      if (E) begin
        ecnt++;
        if (F !== v.dir) dirok = 1'b0;
      end
      if (done != 2'b00) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d done seen", idx), got, 1);
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d done id", idx), done, v.gnt);
    chk($sformatf("v%0d err", idx), err, v.err);
    chk($sformatf("v%0d E cycles", idx), ecnt, v.steps);
    chk($sformatf("v%0d F dir", idx), dirok, 1);
    chk($sformatf("v%0d final present", idx), present, v.fin);
    @(negedge clk);
    #1 chk($sformatf("v%0d done pulse width", idx), done, 0);
    chk($sformatf("v%0d idle after done", idx), busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int   ndone;
    int   exp_id;
    int   last_id;
    logic saw;

    // p, valid, t0, t1, hold, gnt, lat, steps, dir, err, fin
    vecs[0] = '{2'd0, 2'b01, 2'd1, 2'd0, 1'b0, 2'b01, 3, 1, 1'b1, 1'b0, 2'd1};
    vecs[1] = '{2'd0, 2'b10, 2'd0, 2'd3, 1'b0, 2'b10, 3, 1, 1'b0, 1'b0, 2'd3};
    vecs[2] = '{2'd1, 2'b01, 2'd3, 2'd0, 1'b0, 2'b01, 4, 2, 1'b1, 1'b0, 2'd3};
    vecs[3] = '{2'd2, 2'b10, 2'd0, 2'd2, 1'b0, 2'b10, 2, 0, 1'b0, 1'b0, 2'd2};
    vecs[4] = '{2'd3, 2'b01, 2'd1, 2'd0, 1'b0, 2'b01, 4, 2, 1'b1, 1'b0, 2'd1};
    vecs[5] = '{2'd2, 2'b01, 2'd1, 2'd3, 1'b0, 2'b01, 3, 1, 1'b0, 1'b0, 2'd1};
    // Pointer is 1 here (last grant went to 0), so contention goes to requester 1.
    vecs[6] = '{2'd0, 2'b11, 2'd2, 2'd0, 1'b0, 2'b10, 2, 0, 1'b0, 1'b0, 2'd0};
    // Counter stalled: abort after six steps.
    vecs[7] = '{2'd0, 2'b01, 2'd2, 2'd0, 1'b1, 2'b01, 8, 6, 1'b1, 1'b1, 2'd0};

    reset     = 1'b0;
    req_valid = 2'b00;
    tgt0      = 2'd0;
    tgt1      = 2'd0;
    hold      = 1'b0;
    load      = 1'b1;
    load_val  = 2'd0;
    @(negedge clk);
    load = 1'b0;
    #1;
    chk("reset E", E, 0);
    chk("reset F", F, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    req_valid = 2'b10;
    #1 chk("post-reset ready follows valid", req_ready, 2'b10);
    req_valid = 2'b00;
    #1 chk("post-reset ready idle", req_ready, 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    hold = 1'b0;

    // Continuous contention: grants alternate, none while busy, done id follows grant.
    set_present(2'd0);
    tgt0      = 2'd2;
    tgt1      = 2'd0;
    req_valid = 2'b11;
    exp_id    = 1;
    last_id   = 0;
    ndone     = 0;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      #1;
      if (busy) chk("rr no grant while busy", req_ready, 0);
      if ((req_ready & req_valid) != 2'b00) begin
        chk("rr grant order", req_ready, (exp_id == 1) ? 2 : 1);
        last_id = req_ready[1] ? 1 : 0;
        exp_id  = 1 - exp_id;
      end
      if (done != 2'b00) begin
        chk("rr done id", done, (last_id == 1) ? 2 : 1);
        ndone++;
      end
      @(negedge clk);
    end
    chk("rr done count", ndone, 4);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset mid-move drops the request and restarts the pointer at requester 0.
    set_present(2'd0);
    tgt1      = 2'd2;
    req_valid = 2'b10;
    #1 chk("rst accept", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rst moving E", E, 1);
    chk("rst moving busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst E", E, 0);
    chk("rst F", F, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    saw   = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1 if (done != 2'b00) saw = 1'b1;
      @(negedge clk);
    end
    chk("rst no done for dropped request", saw, 0);
    tgt0      = present;
    req_valid = 2'b11;
    #1 chk("rst pointer back to 0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    saw = 1'b0;
    for (int c = 0; c < 10 && !saw; c++) begin
      #1 if (done != 2'b00) begin
        saw = 1'b1;
        chk("rst next done id", done, 2'b01);
      end
      @(negedge clk);
    end
    chk("rst next done seen", saw, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
